// File: rtl/clk_sel_pkg.sv
// ============================================================================
// Module   : clk_sel_pkg
// Purpose  : Shared types and constants for the clock-source sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_sel_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        SWITCH    = 2'd2,
        SETTLE    = 2'd3
    } state_e;

    localparam logic SEL_CLK0 = 1'b0;
    localparam logic SEL_CLK1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/clk_sel_lock_filter.sv
// ============================================================================
// Module   : clk_sel_lock_filter
// Purpose  : Synchronises the PLL lock and qualifies it after a stable run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_sel_lock_filter #(
    parameter int LOCK_STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_async_i,
    output logic lock_s_o,
    output logic lock_ok_o
);

    localparam int              CW      = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(LOCK_STABLE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= lock_async_i;
            sync2_q <= sync1_q;
            // Any single low sample restarts qualification.
            if (!sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign lock_s_o  = sync2_q;
    assign lock_ok_o = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/clk_sel_ctrl.sv
// ============================================================================
// Module   : clk_sel_ctrl
// Purpose  : Clock-source sequencer driving a glitch-free switch's sel_clk.
//            Optional macro CLK_SEL_LOCK_TIMEOUT_EN adds a WAIT_LOCK timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int SETTLE_CYCLES      = 8,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic pll_lock_async,
    input  logic err_clr,
    output logic sel_clk,
    output logic cur_sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int             SCW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_CYCLES);

    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_lock
        $error("LOCK_STABLE_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic           lock_s;
    logic           lock_ok;
    state_e         state_q;
    logic           target_q;
    logic           sel_clk_q;
    logic           cur_sel_q;
    logic           done_q;
    logic           err_q;
    logic           fb_pend_q;
    logic           silent_q;
    logic [SCW-1:0] settle_q;
    logic           fb_now;
    logic           fallback_pending;
    logic           accept;

`ifdef CLK_SEL_LOCK_TIMEOUT_EN
    localparam int             TCW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0] to_cnt_q;
`endif

    clk_sel_lock_filter #(
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES)
    ) u_lock_filter (
        .clk          (clk),
        .rst          (rst),
        .lock_async_i (pll_lock_async),
        .lock_s_o     (lock_s),
        .lock_ok_o    (lock_ok)
    );

    // Only a settled or in-progress move onto clk1 can be undermined by lock loss.
    assign fb_now           = ~lock_s & sel_clk_q & target_q;
    assign fallback_pending = fb_pend_q | fb_now;
    assign req_ready        = (state_q == IDLE) & ~fallback_pending;
    assign accept           = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= SEL_CLK0;
            sel_clk_q <= SEL_CLK0;
            cur_sel_q <= SEL_CLK0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fb_pend_q <= 1'b0;
            silent_q  <= 1'b0;
            settle_q  <= '0;
`ifdef CLK_SEL_LOCK_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (fb_now) begin
                fb_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (fallback_pending) begin
                        target_q  <= SEL_CLK0;
                        silent_q  <= 1'b1;
                        err_q     <= 1'b1;
                        fb_pend_q <= 1'b0;
                        state_q   <= SWITCH;
                    end else if (accept) begin
                        target_q <= req_sel;
                        silent_q <= 1'b0;
                        if (req_sel == cur_sel_q) begin
                            done_q <= 1'b1;
                        end else if (req_sel == SEL_CLK0) begin
                            state_q <= SWITCH;
                        end else begin
                            state_q <= WAIT_LOCK;
`ifdef CLK_SEL_LOCK_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_q <= SWITCH;
`ifdef CLK_SEL_LOCK_TIMEOUT_EN
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q    <= 1'b1;
                        target_q <= cur_sel_q;
                        state_q  <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
`endif
                    end
                end
                SWITCH: begin
                    sel_clk_q <= target_q;
                    settle_q  <= '0;
                    state_q   <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_MAX) begin
                        cur_sel_q <= target_q;
                        done_q    <= ~silent_q;
                        state_q   <= IDLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_clk = sel_clk_q;
    assign cur_sel = cur_sel_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

`default_nettype wire

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
SCU clock-source sequencer that drives the sel_clk input of the glitch-free clock switch directly downstream of it. It accepts software switch requests and qualifies the PLL lock before selecting the PLL clock (clk1). It holds off completion until the switch's internal handshake has settled, and automatically falls back to the reference clock (clk0) on loss of lock. It runs on the always-on reference clock.

Parameters:
LOCK_STABLE_CYCLES, 16, consecutive synchronized-lock cycles required before lock is qualified (>=1)
SETTLE_CYCLES, 8, cycles waited after changing sel_clk before completion (must cover the downstream switch latency, >=1)
TIMEOUT_CYCLES, 4096, WAIT_LOCK abort limit; used only with the optional feature

Ports:
clk  in  1  always-on reference clock (same source as downstream clk0)
rst  in  1  synchronous reset, active-high
req_valid  in  1  switch request
req_sel  in  1  requested source: 0 = clk0/reference, 1 = clk1/PLL
req_ready  out  1  request accepted when req_valid & req_ready
pll_lock_async  in  1  PLL lock, asynchronous to clk
err_clr  in  1  clears err
sel_clk  out  1  to clock switch sel_clk
cur_sel  out  1  source in effect (updates only after settle)
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse on request completion
err  out  1  sticky: lock timeout or lock lost while on clk1

Behaviour:
- Reset values: sel_clk=0, cur_sel=0, busy=0, done=0, err=0, req_ready=1. Synchronizer flops=0, counters=0, state=IDLE. Reset mid-operation aborts immediately to these values.
- Lock filter: 2-flop synchronizer gives lock_s (2-cycle latency). The stable counter increments while lock_s=1, saturates at LOCK_STABLE_CYCLES and clears to 0 in any cycle lock_s=0. lock_ok = (cnt==LOCK_STABLE_CYCLES). Counter width = $clog2(LOCK_STABLE_CYCLES+1).
- req_ready = (state==IDLE) & ~fallback_pending. req_sel is captured into target on acceptance; req_valid while not ready is ignored (no queueing).
- FSM states: IDLE, WAIT_LOCK, SWITCH, SETTLE.
- IDLE + accept:
  - req_sel==cur_sel: no-op; done pulses next cycle; stay IDLE.
  - req_sel==0: go to SWITCH.
  - req_sel==1: go to WAIT_LOCK.
- WAIT_LOCK: go to SWITCH in the first cycle lock_ok=1. Lock may bounce; the stable counter restarts.
- SWITCH: lasts 1 cycle; sel_clk<=target; settle counter<=0; go to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles. On the terminal cycle: cur_sel<=target, done<=1 for 1 cycle, go to IDLE.
- Latency: clk0 request accepted at cycle N gives sel_clk change at N+2 and done at N+3+SETTLE_CYCLES.
- Fallback: fallback_pending sets when lock_s=0 while sel_clk=1 (any state).
  - In IDLE: target<=0, go to SWITCH, err<=1. Not reported via done.
  - In SETTLE toward 1: settle completes normally (done pulses), then fallback is taken from IDLE the next cycle.
- err: set by fallback or timeout; cleared by err_clr. Set and clear in the same cycle: set wins.
- busy=1 in WAIT_LOCK/SWITCH/SETTLE.

Optional Feature:
CLK_SEL_LOCK_TIMEOUT_EN.
- Defined: a timeout counter runs in WAIT_LOCK. Reaching TIMEOUT_CYCLES gives err<=1, sel_clk unchanged (0), return to IDLE, and no done pulse.
- Undefined: WAIT_LOCK waits indefinitely; TIMEOUT_CYCLES is unused and no counter is built.

Decomposition:
- Package clk_sel_pkg: state enum (IDLE, WAIT_LOCK, SWITCH, SETTLE); constants SEL_CLK0=1'b0, SEL_CLK1=1'b1.
- Sub-module clk_sel_lock_filter: synchronizer plus stable counter; outputs lock_s and lock_ok; parameter LOCK_STABLE_CYCLES.

Test Plan:
- Reset, then lock held 1, req_sel=1 at cycle 10 -> WAIT_LOCK; sel_clk=1 after lock_ok (>=2+16 cycles of lock); done after 8 more cycles; cur_sel=1; err=0.
- On clk1, req_sel=0 at cycle N -> sel_clk=0 at N+2, done at N+11, cur_sel=0, no lock dependency.
- req_sel equal to cur_sel -> done next cycle, sel_clk stable, busy never asserts.
- On clk1, drop pll_lock_async for 5 cycles -> sel_clk=0 within 4 cycles, err=1, no done; err_clr asserted alone clears err; err_clr coincident with new fallback leaves err=1.
- With CLK_SEL_LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=64, lock never asserted -> after 64 cycles in WAIT_LOCK: IDLE, err=1, sel_clk=0, no done. Without the macro the FSM stays in WAIT_LOCK for 1000 cycles.
- rst pulsed during SETTLE toward clk1 -> next cycle sel_clk=0, cur_sel=0, busy=0, req_ready=1; a req_valid during busy is ignored.
